// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the LAMBA core.
// Keeps one request outstanding to a variable-latency imem; handles stall and redirect.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc1,
    output logic [5:0]            if_id_opcode,
    output logic [5:0]            if_id_funct
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [ADDR_WIDTH-1:0] fetch_next;
    logic [DATA_WIDTH-1:0] skid_instr;
    logic [ADDR_WIDTH-1:0] skid_pc1;

    assign fetch_next   = fetch_addr + ADDR_WIDTH'(1);
    assign imem_addr    = fetch_addr;
    assign imem_req     = rst && (state != HOLD);
    assign if_id_opcode = if_id_instr[31:26];
    assign if_id_funct  = if_id_instr[5:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            fetch_addr  <= RESET_PC;
            skid_instr  <= '0;
            skid_pc1    <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc1   <= '0;
        end else if (redirect_en) begin
            // A request still in flight must be drained (DISCARD) before the target is issued.
            if_id_valid <= 1'b0;
            pc          <= redirect_pc;
            skid_instr  <= '0;
            skid_pc1    <= '0;
            case (state)
                FETCH: begin
                    if (imem_ack) fetch_addr <= redirect_pc;
                    else          state      <= DISCARD;
                end
                DISCARD: begin
                    if (imem_ack) begin
                        fetch_addr <= redirect_pc;
                        state      <= FETCH;
                    end
                end
                default: begin
                    fetch_addr <= redirect_pc;
                    state      <= FETCH;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        fetch_addr <= fetch_next;
                        pc         <= fetch_next;
                        if (stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc1   <= fetch_next;
                            state      <= HOLD;
                        end else begin
                            if_id_instr <= imem_rdata;
                            if_id_pc1   <= fetch_next;
                            if_id_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_instr <= skid_instr;
                        if_id_pc1   <= skid_pc1;
                        if_id_valid <= 1'b1;
                        skid_instr  <= '0;
                        skid_pc1    <= '0;
                        state       <= FETCH;
                    end
                end
                DISCARD: begin
                    if (!stall) if_id_valid <= 1'b0;
                    if (imem_ack) begin
                        fetch_addr <= pc;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected IF/ID contents,
// a negedge monitor pops and compares each new delivery.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc1;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc1;
    logic [5:0]  if_id_opcode;
    logic [5:0]  if_id_funct;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc1;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_on = 1'b0;

    logic        mem_on = 1'b0;
    int unsigned lat = 0;
    int unsigned wait_cnt = 0;
    logic        prev_stall = 1'b0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc1(if_id_pc1),
        .if_id_opcode(if_id_opcode), .if_id_funct(if_id_funct)
    );

    fetch_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect_en(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .if_id_valid(w_valid), .if_id_instr(w_instr), .if_id_pc1(w_pc1),
        .if_id_opcode(w_opcode), .if_id_funct(w_funct)
    );

    // Memory model: data = address*3, ack after `lat` waiting cycles.
    assign imem_ack   = mem_on && imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_addr * 32'd3;
    assign w_ack      = w_on && w_req;
    assign w_rdata    = w_addr * 32'd3;

    always @(posedge clk) begin
        prev_stall <= stall;
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // IF/ID is freshly loaded exactly when it is valid after an edge that saw stall=0.
    always @(negedge clk) begin
        if (rst && if_id_valid && !prev_stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery: got pc1=%h instr=%h expected none", if_id_pc1, if_id_instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pc1", if_id_pc1, e.pc1);
                check("instr", if_id_instr, e.instr);
                check("opcode", {26'd0, if_id_opcode}, {26'd0, e.instr[31:26]});
                check("funct", {26'd0, if_id_funct}, {26'd0, e.instr[5:0]});
            end
        end
    end

    task automatic push_addr(input logic [31:0] a);
        exp_t e;
        e.pc1   = a + 32'd1;
        e.instr = a * 32'd3;
        sb.push_back(e);
    endtask

    task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
        for (logic [32:0] a = {1'b0, lo}; a <= {1'b0, hi}; a++) push_addr(a[31:0]);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        #1;
        check(name, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        mem_on      = 1'b0;
        w_on        = 1'b0;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        lat         = 0;
        rst         = 1'b0;
        #1;
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc1", if_id_pc1, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        step(2);
    endtask

    initial begin
        // Back-to-back fetch, ack every cycle.
        do_reset();
        push_range(0, 5);
        mem_on = 1'b1;
        rst    = 1'b1;
        step(6);
        mem_on = 1'b0;
        drain("a_one_per_cycle");
        step(1);
        check("a_bubble_valid", {31'd0, if_id_valid}, 32'd0);
        check("a_next_addr", imem_addr, 32'd6);
        check("a_req", {31'd0, imem_req}, 32'd1);

        // Three-cycle latency: two bubbles, address held.
        do_reset();
        push_range(0, 2);
        mem_on = 1'b1;
        lat    = 2;
        rst    = 1'b1;
        step(4);
        check("b_bubble1", {31'd0, if_id_valid}, 32'd0);
        check("b_addr_hold1", imem_addr, 32'd1);
        step(1);
        check("b_bubble2", {31'd0, if_id_valid}, 32'd0);
        check("b_addr_hold2", imem_addr, 32'd1);
        step(4);
        mem_on = 1'b0;
        drain("b_drain");

        // Stall while the ack for address 5 arrives.
        do_reset();
        push_range(0, 7);
        mem_on = 1'b1;
        rst    = 1'b1;
        step(5);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("c_hold_req", {31'd0, imem_req}, 32'd0);
            check("c_hold_pc1", if_id_pc1, 32'd5);
            check("c_hold_valid", {31'd0, if_id_valid}, 32'd1);
        end
        stall = 1'b0;
        step(1);
        check("c_resume_addr", imem_addr, 32'd6);
        step(2);
        mem_on = 1'b0;
        drain("c_drain");

        // Redirect while address 7 is outstanding.
        do_reset();
        push_range(0, 6);
        push_addr(32'h40);
        push_addr(32'h41);
        mem_on = 1'b1;
        rst    = 1'b1;
        step(7);
        lat         = 2;
        redirect_en = 1'b1;
        redirect_pc = 32'h40;
        step(1);
        redirect_en = 1'b0;
        check("d_flush_valid", {31'd0, if_id_valid}, 32'd0);
        check("d_stale_addr", imem_addr, 32'd7);
        check("d_stale_req", {31'd0, imem_req}, 32'd1);
        step(1);
        check("d_stale_addr2", imem_addr, 32'd7);
        step(1);
        check("d_target_addr", imem_addr, 32'h40);
        check("d_drop_valid", {31'd0, if_id_valid}, 32'd0);
        lat = 0;
        step(2);
        mem_on = 1'b0;
        drain("d_drain");

        // Redirect, ack and stall in the same cycle.
        do_reset();
        push_range(0, 2);
        push_addr(32'h100);
        push_addr(32'h101);
        mem_on = 1'b1;
        rst    = 1'b1;
        step(3);
        stall       = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h100;
        step(1);
        check("e_no_hold_req", {31'd0, imem_req}, 32'd1);
        check("e_target_addr", imem_addr, 32'h100);
        check("e_flush_valid", {31'd0, if_id_valid}, 32'd0);
        stall       = 1'b0;
        redirect_en = 1'b0;
        step(2);
        mem_on = 1'b0;
        drain("e_drain");

        // Second redirect during DISCARD: only the latest target is fetched.
        do_reset();
        push_addr(32'h30);
        mem_on      = 1'b1;
        lat         = 3;
        redirect_en = 1'b1;
        redirect_pc = 32'h20;
        rst         = 1'b1;
        step(1);
        check("g_stale_addr", imem_addr, 32'd0);
        redirect_pc = 32'h30;
        step(1);
        redirect_en = 1'b0;
        step(1);
        check("g_stale_addr2", imem_addr, 32'd0);
        step(1);
        check("g_latest_addr", imem_addr, 32'h30);
        lat = 0;
        step(1);
        mem_on = 1'b0;
        drain("g_drain");

        // All-ones reset PC wraps to 0.
        do_reset();
        check("w_rst_addr", w_addr, 32'hFFFF_FFFF);
        check("w_rst_req", {31'd0, w_req}, 32'd0);
        w_on = 1'b1;
        rst  = 1'b1;
        step(1);
        check("w_valid", {31'd0, w_valid}, 32'd1);
        check("w_pc1_wrap", w_pc1, 32'd0);
        check("w_instr", w_instr, 32'hFFFF_FFFD);
        check("w_opcode", {26'd0, w_opcode}, 32'h3F);
        check("w_funct", {26'd0, w_funct}, 32'h3D);
        check("w_second_addr", w_addr, 32'd0);
        step(1);
        check("w_pc1_next", w_pc1, 32'd1);
        check("w_instr_next", w_instr, 32'd0);
        check("w_addr_next", w_addr, 32'd1);
        w_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
